// File: rtl/axi_rd_data_arbiter.sv
// Merges NUM_SRC AXI R channels onto one master R channel. Arbitration is
// round-robin at burst granularity; a granted source holds the channel until its rlast beat.
module axi_rd_data_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              s_rvalid,
    output logic [NUM_SRC-1:0]              s_rready,
    input  logic [NUM_SRC*ID_MAX_WIDTH-1:0] s_rid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_rdata,
    input  logic [NUM_SRC*2-1:0]            s_rresp,
    input  logic [NUM_SRC-1:0]              s_rlast,
    input  logic [NUM_SRC-1:0]              s_ruser,
    output logic                            m_rvalid,
    output logic [ID_MAX_WIDTH-1:0]         m_rid,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [1:0]                      m_rresp,
    output logic                            m_rlast,
    output logic                            m_ruser,
    input  logic                            m_rready,
    output logic [$clog2(NUM_SRC)-1:0]      m_rsrc,
    output logic                            busy,
    output logic [7:0]                      beat_cnt
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] cand;
    logic             any_valid;
    logic [7:0]       cnt_q;
    logic             sel_valid;
    logic             xfer;
    int               rr_idx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Round-robin: first valid source strictly after last_grant, wrapping.
    always_comb begin
        winner    = last_grant;
        any_valid = 1'b0;
        rr_idx    = 0;
        cand      = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            rr_idx = (int'(last_grant) + i) % NUM_SRC;
            cand   = SRC_W'(rr_idx);
            if (!any_valid && s_rvalid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        sel_valid = s_rvalid[0];
        m_rid     = s_rid[0 +: ID_MAX_WIDTH];
        m_rdata   = s_rdata[0 +: DATA_WIDTH];
        m_rresp   = s_rresp[0 +: 2];
        m_rlast   = s_rlast[0];
        m_ruser   = s_ruser[0];
        s_rready  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant == SRC_W'(k)) begin
                sel_valid = s_rvalid[k];
                m_rid     = s_rid[k*ID_MAX_WIDTH +: ID_MAX_WIDTH];
                m_rdata   = s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                m_rresp   = s_rresp[k*2 +: 2];
                m_rlast   = s_rlast[k];
                m_ruser   = s_ruser[k];
                s_rready[k] = (state == LOCKED) && m_rready;
            end
        end
    end

    assign m_rvalid = (state == LOCKED) && sel_valid;
    assign xfer     = m_rvalid && m_rready;
    assign busy     = (state == LOCKED);
    assign m_rsrc   = grant;
    // Includes the beat handshaking this cycle, so the rlast beat still reports the full count.
    assign beat_cnt = xfer ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_SRC;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= winner;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (m_rlast) begin
                            state      <= IDLE;
                            last_grant <= grant;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_data_arbiter.sv
// Scoreboard bench for axi_rd_data_arbiter: per-source beat queues feed the DUT,
// expected master beats are queued in predicted grant order and compared on each handshake.
module tb_axi_rd_data_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [N*IW-1:0] s_rid;
    logic [N*DW-1:0] s_rdata;
    logic [N*2-1:0]  s_rresp;
    logic [N-1:0]    s_rlast;
    logic [N-1:0]    s_ruser;
    logic            m_rvalid;
    logic [IW-1:0]   m_rid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            m_ruser;
    logic            m_rready;
    logic [1:0]      m_rsrc;
    logic            busy;
    logic [7:0]      beat_cnt;

    always #5 clk = ~clk;

    axi_rd_data_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_MAX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
        .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_ruser(m_ruser), .m_rready(m_rready),
        .m_rsrc(m_rsrc), .busy(busy), .beat_cnt(beat_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
        logic          user;
        int            cnt;
    } exp_t;

    beat_t  srcq[N][$];
    exp_t   expq[$];
    logic [N-1:0] en;
    int     rdy_mode;
    int     cyc;
    int     beats_seen;
    int     last_beat_cyc;
    int     beat_gap;
    int     n_chk = 0;
    int     n_pass = 0;

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            if (en[k] && srcq[k].size() > 0) begin
                s_rvalid[k]         = 1'b1;
                s_rid[k*IW +: IW]   = srcq[k][0].id;
                s_rdata[k*DW +: DW] = srcq[k][0].data;
                s_rresp[k*2 +: 2]   = srcq[k][0].resp;
                s_rlast[k]          = srcq[k][0].last;
                s_ruser[k]          = srcq[k][0].user;
            end else begin
                s_rvalid[k]         = 1'b0;
                s_rid[k*IW +: IW]   = '0;
                s_rdata[k*DW +: DW] = '0;
                s_rresp[k*2 +: 2]   = '0;
                s_rlast[k]          = 1'b0;
                s_ruser[k]          = 1'b0;
            end
        end
        m_rready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    endtask

    task automatic add_burst(input int src, input int nb, input logic [DW-1:0] base,
                             input int err_beat, input logic [1:0] err_resp);
        beat_t b;
        exp_t  e;
        for (int i = 1; i <= nb; i++) begin
            b.data = base + DW'(i);
            b.id   = IW'(src * 3 + i);
            b.resp = (i == err_beat) ? err_resp : 2'b00;
            b.last = (i == nb);
            b.user = i[0];
            srcq[src].push_back(b);
            e.src = src; e.data = b.data; e.id = b.id; e.resp = b.resp;
            e.last = b.last; e.user = b.user; e.cnt = (i > 255) ? 255 : i;
            expq.push_back(e);
        end
    endtask

    // One clock: sample #1 after the falling edge, score any master beat, advance sources.
    task automatic sb_cycle();
        logic [N-1:0] hs;
        exp_t e;
        #1;
        hs = s_rvalid & s_rready;
        if (m_rvalid && m_rready) begin
            n_chk++;
            if (expq.size() == 0) begin
                $display("FAIL sb_unexpected: got beat rdata=%h src=%0d, none expected", m_rdata, m_rsrc);
            end else begin
                n_pass++;
                e = expq.pop_front();
                n_chk++;
                if (m_rsrc !== 2'(e.src)) $display("FAIL sb_src: got %0d want %0d", m_rsrc, e.src);
                else n_pass++;
                n_chk++;
                if (m_rdata !== e.data) $display("FAIL sb_data: got %h want %h", m_rdata, e.data);
                else n_pass++;
                n_chk++;
                if (m_rid !== e.id || m_ruser !== e.user)
                    $display("FAIL sb_id_user: got %h/%b want %h/%b", m_rid, m_ruser, e.id, e.user);
                else n_pass++;
                n_chk++;
                if (m_rresp !== e.resp) $display("FAIL sb_resp: got %b want %b", m_rresp, e.resp);
                else n_pass++;
                n_chk++;
                if (m_rlast !== e.last) $display("FAIL sb_last: got %b want %b", m_rlast, e.last);
                else n_pass++;
                n_chk++;
                if (beat_cnt !== 8'(e.cnt) || busy !== 1'b1)
                    $display("FAIL sb_cnt_busy: got cnt=%0d busy=%b want cnt=%0d busy=1", beat_cnt, busy, e.cnt);
                else n_pass++;
                n_chk++;
                if (hs !== (4'b0001 << e.src))
                    $display("FAIL sb_rready: got s_rvalid&s_rready=%b want one-hot src %0d", hs, e.src);
                else n_pass++;
            end
            beat_gap      = cyc - last_beat_cyc;
            last_beat_cyc = cyc;
            beats_seen++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++)
            if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        apply();
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            sb_cycle();
            n++;
        end
        n_chk++;
        if (expq.size() != 0) $display("FAIL %s_timeout: %0d beats outstanding, want 0", name, expq.size());
        else n_pass++;
    endtask

    task automatic check_idle(input string name);
        #1;
        n_chk++;
        if (busy !== 1'b0 || m_rvalid !== 1'b0 || s_rready !== 4'b0 || beat_cnt !== 8'd0)
            $display("FAIL %s_idle: got busy=%b m_rvalid=%b s_rready=%b beat_cnt=%0d want 0/0/0000/0",
                     name, busy, m_rvalid, s_rready, beat_cnt);
        else n_pass++;
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) srcq[k].delete();
        expq.delete();
        en = '0;
        rst_n = 1'b0;
        apply();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        apply();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = '0;
        apply();
        s_rvalid = 4'hF;
        s_rlast  = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || m_rvalid !== 1'b0) $display("FAIL reset_busy_valid: got %b/%b want 0/0", busy, m_rvalid);
        else n_pass++;
        n_chk++;
        if (s_rready !== 4'b0) $display("FAIL reset_rready: got %b want 0000", s_rready);
        else n_pass++;
        n_chk++;
        if (m_rsrc !== 2'd0 || beat_cnt !== 8'd0) $display("FAIL reset_src_cnt: got %0d/%0d want 0/0", m_rsrc, beat_cnt);
        else n_pass++;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        apply();
    endtask

    task automatic test_single();
        int c0, n;
        add_burst(2, 4, 32'h2000_0000, 0, 2'b00);
        en = 4'b0100;
        apply();
        c0 = cyc;
        n = beats_seen;
        #1;
        n_chk++;
        if (m_rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL single_arb_latency: got m_rvalid=%b busy=%b want 0/0", m_rvalid, busy);
        else n_pass++;
        for (int i = 0; i < 10 && beats_seen == n; i++) sb_cycle();
        n_chk++;
        if (last_beat_cyc - c0 !== 1) $display("FAIL single_first_beat: got cycle %0d want 1", last_beat_cyc - c0);
        else n_pass++;
        drain(20, "single");
        check_idle("single");
    endtask

    task automatic test_contention();
        int b, nb, n;
        do_reset();
        add_burst(0, 1, 32'hC000_0000, 0, 2'b00);
        add_burst(1, 1, 32'hC100_0000, 0, 2'b00);
        add_burst(2, 1, 32'hC200_0000, 0, 2'b00);
        add_burst(3, 1, 32'hC300_0000, 0, 2'b00);
        add_burst(0, 1, 32'hC400_0000, 0, 2'b00);
        en = 4'hF;
        apply();
        b = beats_seen; nb = 0; n = 0;
        while (expq.size() > 0 && n < 40) begin
            sb_cycle();
            n++;
            if (beats_seen != b) begin
                b = beats_seen;
                nb++;
                if (nb > 1) begin
                    n_chk++;
                    if (beat_gap !== 2) $display("FAIL contention_gap: got %0d cycles between beats want 2", beat_gap);
                    else n_pass++;
                end
            end
        end
        drain(1, "contention");
        check_idle("contention");
    endtask

    task automatic test_lock_hold();
        int b0, n;
        add_burst(1, 8, 32'h1100_0000, 0, 2'b00);
        add_burst(0, 1, 32'h0100_0000, 0, 2'b00);
        en = 4'b0010;
        apply();
        b0 = beats_seen; n = 0;
        while (beats_seen - b0 < 8 && n < 40) begin
            if (beats_seen - b0 >= 2 && en[0] == 1'b0) begin
                en[0] = 1'b1;
                apply();
            end
            #1;
            n_chk++;
            if (s_rready[0] !== 1'b0) $display("FAIL lock_hold_rready0: got %b want 0 at src1 beat %0d", s_rready[0], beats_seen - b0 + 1);
            else n_pass++;
            sb_cycle();
            n++;
        end
        drain(10, "lock_hold");
        check_idle("lock_hold");
    endtask

    task automatic test_valid_drop();
        int b0, n;
        add_burst(2, 4, 32'h2200_0000, 0, 2'b00);
        add_burst(3, 1, 32'h3300_0000, 0, 2'b00);
        en = 4'b0100;
        apply();
        b0 = beats_seen; n = 0;
        while (beats_seen - b0 < 2 && n < 10) begin sb_cycle(); n++; end
        en = 4'b1000;
        apply();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++;
            if (busy !== 1'b1 || m_rvalid !== 1'b0 || m_rsrc !== 2'd2 || s_rready[3] !== 1'b0)
                $display("FAIL valid_drop_hold: got busy=%b m_rvalid=%b m_rsrc=%0d rready3=%b want 1/0/2/0",
                         busy, m_rvalid, m_rsrc, s_rready[3]);
            else n_pass++;
            sb_cycle();
        end
        en = 4'b1100;
        apply();
        drain(20, "valid_drop");
        check_idle("valid_drop");
    endtask

    task automatic test_backpressure();
        int b0, n;
        rdy_mode = 1;
        add_burst(0, 3, 32'hB000_0000, 0, 2'b00);
        en = 4'b0001;
        apply();
        b0 = beats_seen; n = 0;
        while (expq.size() > 0 && n < 30) begin
            #1;
            if (m_rvalid && !m_rready) begin
                n_chk++;
                if (beat_cnt !== 8'(beats_seen - b0)) $display("FAIL backpressure_stall_cnt: got %0d want %0d", beat_cnt, beats_seen - b0);
                else n_pass++;
            end
            sb_cycle();
            n++;
        end
        drain(1, "backpressure");
        rdy_mode = 0;
        apply();
        check_idle("backpressure");
    endtask

    task automatic test_error();
        add_burst(3, 3, 32'hE000_0000, 1, 2'b10);
        en = 4'b1000;
        apply();
        drain(20, "error_slverr");
        add_burst(3, 3, 32'hE100_0000, 2, 2'b11);
        apply();
        drain(20, "error_decerr");
        check_idle("error");
    endtask

    task automatic test_saturation();
        add_burst(1, 300, 32'h5A00_0000, 0, 2'b00);
        en = 4'b0010;
        apply();
        drain(400, "saturation");
        check_idle("saturation");
    endtask

    task automatic test_reset_mid();
        int b0, n;
        add_burst(1, 5, 32'hD100_0000, 0, 2'b00);
        en = 4'b0010;
        apply();
        b0 = beats_seen; n = 0;
        while (beats_seen - b0 < 1 && n < 10) begin sb_cycle(); n++; end
        #1;
        n_chk++;
        if (busy !== 1'b1 || m_rvalid !== 1'b1) $display("FAIL reset_mid_pre: got busy=%b m_rvalid=%b want 1/1", busy, m_rvalid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || m_rvalid !== 1'b0 || s_rready !== 4'b0)
            $display("FAIL reset_mid_async: got busy=%b m_rvalid=%b s_rready=%b want 0/0/0000", busy, m_rvalid, s_rready);
        else n_pass++;
        n_chk++;
        if (beat_cnt !== 8'd0 || m_rsrc !== 2'd0) $display("FAIL reset_mid_cnt: got cnt=%0d src=%0d want 0/0", beat_cnt, m_rsrc);
        else n_pass++;
        for (int k = 0; k < N; k++) srcq[k].delete();
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        add_burst(0, 1, 32'hD200_0000, 0, 2'b00);
        add_burst(1, 1, 32'hD300_0000, 0, 2'b00);
        add_burst(3, 1, 32'hD400_0000, 0, 2'b00);
        en = 4'b1011;
        apply();
        drain(20, "reset_mid_prio");
        check_idle("reset_mid");
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0;
        rdy_mode = 0;
        cyc = 0;
        beats_seen = 0;
        last_beat_cyc = 0;
        beat_gap = 0;
        apply();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_lock_hold();
        test_valid_drop();
        test_backpressure();
        test_error();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
